instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage of the RISC-V core: owns the PC, issues one-outstanding-request fetches to instruction memory over a req/ready handshake, and loads the IF/ID pipeline register whose `if_id_opcode` feeds the control unit's opcode decode. It absorbs decode stalls with a one-entry skid buffer and accepts branch/jump redirects from execute, flushing wrong-path instructions as NOPs.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset
- `NOP_INSTR`, 32'h0000_0013, instruction word (addi x0,x0,0) loaded on reset/flush
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, synchronous, active-high
- `imem_req` out 1: fetch request valid
- `imem_addr` out 32: fetch address, word aligned
- `imem_ready` in 1: memory returns `imem_rdata` for `imem_addr` this cycle
- `imem_rdata` in 32: instruction word
- `stall` in 1: IF/ID register must hold (hazard unit)
- `redirect` in 1: taken branch/jump from execute
- `redirect_pc` in 32: target; bits [1:0] ignored (forced 0)
- `if_id_valid` out 1: IF/ID holds a real instruction
- `if_id_pc` out 32: PC of IF/ID instruction
- `if_id_instr` out 32: IF/ID instruction word
- `if_id_opcode` out 7: `if_id_instr[6:0]`, to control unit

## Operation
- Registers: `pc` (next fetch), `req_addr`, skid buffer {`buf_pc`,`buf_instr`}, IF/ID register, FSM state.
- States: REQ, DISCARD, BUF. `imem_req`=1 in REQ and DISCARD; 0 in BUF. `imem_addr`=`req_addr`.
- Handshake: once `imem_req` is 1, `imem_addr` stays stable until a cycle with `imem_ready`=1 (request completes). Exactly one request outstanding.
- REQ, `imem_ready`=1, `stall`=0: IF/ID <= {1, `req_addr`, `imem_rdata`}; `pc`,`req_addr` <= `req_addr`+4; stay REQ.
- REQ, `imem_ready`=1, `stall`=1: buffer <= {`req_addr`, `imem_rdata`}; `pc`,`req_addr` <= `req_addr`+4; -> BUF.
- REQ, `imem_ready`=0: hold; if `stall`=0, `if_id_valid` <= 0 (bubble); if `stall`=1, IF/ID holds.
- BUF, `stall`=1: hold everything. BUF, `stall`=0: IF/ID <= {1, buffer}; -> REQ.
- Redirect (highest priority, any state): `pc` <= {`redirect_pc`[31:2],2'b00}; IF/ID <= {0, `pc` unchanged, `NOP_INSTR`}; buffer discarded; overrides `stall`.
  - From REQ with `imem_ready`=1 or from BUF: `req_addr` <= new pc; -> REQ (response this cycle dropped).
  - From REQ with `imem_ready`=0: -> DISCARD (`req_addr` unchanged).
- DISCARD: on `imem_ready`=1, drop data, `req_addr` <= `pc`, -> REQ. IF/ID stays invalid NOP. A further redirect in DISCARD only updates `pc`.
- PC arithmetic: 32-bit, +4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
- Invalid IF/ID always carries `NOP_INSTR` so control unit decode is harmless.

## Timing
- Reset (while `rst`=1 and the cycle after): state REQ, `pc`=`req_addr`=`RESET_PC`, `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=`NOP_INSTR`, `if_id_opcode`=7'h13; `imem_req`=0 while `rst`=1, 1 from first cycle after `rst` falls. Reset mid-request abandons it; memory tolerates this.
- Fetch latency: ready cycle N -> IF/ID valid from edge N+1. Throughput 1 instr/cycle with `imem_ready` held high and no stall.
- Stall release from BUF: buffered instr in IF/ID one edge after `stall` falls; new request issued the cycle after that.
- Redirect at edge N: `imem_req` to target at N+1 (or after DISCARD drains); target instr valid in IF/ID no earlier than edge N+2.

## Test plan
- Reset, `imem_ready`=1 always, mem[i]=i: `imem_addr` 0,4,8...; `if_id_pc` 0,4,8 on consecutive cycles, `if_id_instr` matches.
- `stall`=1 for 3 cycles while `imem_ready`=1: one instr captured in BUF, `imem_req`=0, IF/ID frozen; after release, no instr lost or duplicated, PCs contiguous.
- `redirect`=1, `redirect_pc`=32'h0000_0103 with ready same cycle: data dropped, `if_id_valid`=0, next `imem_addr`=32'h0000_0100.
- Redirect while request pending (`imem_ready`=0 for 4 cycles): `imem_addr` held at old value until ready, that data discarded, then fetch 32'h100; no wrong-path instr ever valid.
- Redirect and `stall` simultaneously in BUF: buffer dropped, IF/ID flushed to 32'h13 invalid, fetch resumes at target.
- `redirect_pc`=32'hFFFF_FFFC: fetches 32'hFFFF_FFFC then 32'h0000_0000.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a one-outstanding req/ready port, loads IF/ID.
// Latency: imem_ready in cycle N -> IF/ID valid from edge N+1; 1 instr/cycle sustained.
// Backpressure: decode stall parks one response in a skid buffer and drops imem_req until released.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   imem_req/addr       : fetch request to instruction memory (addr held until imem_ready)
//   imem_ready/rdata    : memory completes the current request this cycle
//   stall               : hazard unit asks IF/ID to hold
//   redirect/redirect_pc: taken branch/jump from execute, target low bits forced to zero
//   if_id_*             : IF/ID pipeline register; opcode slice feeds the control unit
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [6:0]  if_id_opcode
);

    // REQ: request in flight for a correct-path address.
    // DISCARD: request in flight for a wrong-path address; its response is dropped.
    // BUF: skid buffer full, no request issued.
    typedef enum logic [1:0] {S_REQ, S_DISCARD, S_BUF} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        vld_q, vld_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifinstr_q, ifinstr_d;

    logic [31:0] target;
    logic [31:0] seq_addr;
    logic        unused_rpc_lsb;

    assign target         = {redirect_pc[31:2], 2'b00};
    assign seq_addr       = req_addr_q + 32'd4;   // wraps silently at the top of memory
    assign unused_rpc_lsb = ^redirect_pc[1:0];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        vld_d       = vld_q;
        ifpc_d      = ifpc_q;
        ifinstr_d   = ifinstr_q;

        if (redirect) begin
            // Flush wins over stall; IF/ID keeps its PC but becomes a harmless NOP.
            pc_d      = target;
            vld_d     = 1'b0;
            ifinstr_d = NOP_INSTR;
            case (state_q)
                S_REQ: begin
                    if (imem_ready) begin
                        req_addr_d = target;
                        state_d    = S_REQ;
                    end else begin
                        // Address must stay stable until the pending request completes.
                        state_d = S_DISCARD;
                    end
                end
                S_BUF: begin
                    req_addr_d = target;
                    state_d    = S_REQ;
                end
                S_DISCARD: begin
                    if (imem_ready) begin
                        req_addr_d = target;
                        state_d    = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_ready) begin
                        pc_d       = seq_addr;
                        req_addr_d = seq_addr;
                        if (stall) begin
                            buf_pc_d    = req_addr_q;
                            buf_instr_d = imem_rdata;
                            state_d     = S_BUF;
                        end else begin
                            vld_d     = 1'b1;
                            ifpc_d    = req_addr_q;
                            ifinstr_d = imem_rdata;
                        end
                    end else if (!stall) begin
                        vld_d     = 1'b0;
                        ifinstr_d = NOP_INSTR;
                    end
                end
                S_BUF: begin
                    if (!stall) begin
                        vld_d     = 1'b1;
                        ifpc_d    = buf_pc_q;
                        ifinstr_d = buf_instr_q;
                        state_d   = S_REQ;
                    end
                end
                S_DISCARD: begin
                    // IF/ID was flushed on entry and stays an invalid NOP here.
                    if (imem_ready) begin
                        req_addr_d = pc_q;
                        state_d    = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            buf_pc_q    <= 32'h0;
            buf_instr_q <= NOP_INSTR;
            vld_q       <= 1'b0;
            ifpc_q      <= 32'h0;
            ifinstr_q   <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            vld_q       <= vld_d;
            ifpc_q      <= ifpc_d;
            ifinstr_q   <= ifinstr_d;
        end
    end

    assign imem_req     = ~rst & (state_q != S_BUF);
    assign imem_addr    = req_addr_q;
    assign if_id_valid  = vld_q;
    assign if_id_pc     = ifpc_q;
    assign if_id_instr  = ifinstr_q;
    assign if_id_opcode = ifinstr_q[6:0];

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [6:0]  if_id_opcode;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode)
    );

    int tests = 0;
    int fails = 0;

    // Transaction-level reference: instructions fetched on the correct path but not
    // yet delivered to decode sit in a queue of depth <= 1; a request is issued
    // whenever that queue is empty.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc, m_req_addr;
    bit          m_live;              // outstanding request belongs to the correct path
    logic        m_vld;
    logic [31:0] m_ifpc, m_ifinstr;
    logic [31:0] salt = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc       = 32'h0;
        m_req_addr = 32'h0;
        m_live     = 1'b1;
        m_vld      = 1'b0;
        m_ifpc     = 32'h0;
        m_ifinstr  = NOP;
    endtask

    task automatic check_outputs();
        bit exp_req;
        exp_req = !rst && (q.size() == 0);
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_req_addr);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_vld});
        chk("if_id_pc", if_id_pc, m_ifpc);
        chk("if_id_instr", if_id_instr, m_ifinstr);
        chk("if_id_opcode", {25'b0, if_id_opcode}, {25'b0, m_ifinstr[6:0]});
    endtask

    task automatic model_step();
        bit          req;
        logic [31:0] tgt;
        ent_t        e;
        if (rst) begin
            model_reset();
            return;
        end
        req = (q.size() == 0);
        if (redirect) begin
            tgt       = {redirect_pc[31:2], 2'b00};
            m_vld     = 1'b0;
            m_ifinstr = NOP;
            m_pc      = tgt;
            if (!req || imem_ready) begin
                m_req_addr = tgt;
                m_live     = 1'b1;
            end else begin
                m_live = 1'b0;
            end
            q.delete();
        end else begin
            if (req && imem_ready) begin
                if (m_live) begin
                    q.push_back('{m_req_addr, mem_word(m_req_addr)});
                    m_req_addr = m_req_addr + 32'd4;
                    m_pc       = m_req_addr;
                end else begin
                    m_req_addr = m_pc;
                    m_live     = 1'b1;
                end
            end
            if (!stall) begin
                if (q.size() != 0) begin
                    e         = q.pop_front();
                    m_vld     = 1'b1;
                    m_ifpc    = e.pc;
                    m_ifinstr = e.instr;
                end else begin
                    m_vld     = 1'b0;
                    m_ifinstr = NOP;
                end
            end
        end
    endtask

    // One clock: check current outputs, then apply the inputs for the next edge.
    task automatic step(input bit r, input bit rd, input bit st, input bit rdir,
                        input logic [31:0] rpc);
        @(negedge clk);
        check_outputs();
        rst         = r;
        imem_ready  = rd;
        stall       = st;
        redirect    = rdir;
        redirect_pc = rpc;
        imem_rdata  = mem_word(imem_addr);
        model_step();
    endtask

    initial begin
        model_reset();

        // Reset, then straight-line fetch with memory always ready
        repeat (3) step(1, 1, 0, 0, 0);
        repeat (6) step(0, 1, 0, 0, 0);

        // Stall for three cycles with memory ready, then release
        repeat (3) step(0, 1, 1, 0, 0);
        repeat (5) step(0, 1, 0, 0, 0);

        // Redirect with the response arriving the same cycle
        step(0, 1, 0, 1, 32'h0000_0103);
        repeat (4) step(0, 1, 0, 0, 0);

        // Redirect while the request is pending for four cycles
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0000_0103);
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (4) step(0, 1, 0, 0, 0);

        // Redirect and stall together while the skid buffer is full
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 32'h0000_0200);
        repeat (4) step(0, 1, 0, 0, 0);

        // Second redirect while already draining a wrong-path request
        step(0, 0, 0, 1, 32'h0000_0300);
        step(0, 0, 0, 1, 32'h0000_0400);
        repeat (4) step(0, 1, 0, 0, 0);

        // PC wrap at the top of the address space
        step(0, 1, 0, 1, 32'hFFFF_FFFC);
        repeat (4) step(0, 1, 0, 0, 0);

        // Randomized traffic with occasional resets
        salt = 32'hA5C3_0000;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + {30'b0, 2'($urandom)} : $urandom;
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 11) == 0),
                 rpc);
        end
        step(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
